// File: rtl/ext_pipe.sv
// Immediate/offset extension unit with a two-entry registered output buffer.
// Optional macro EXT_JUMP_EN makes eop 101 a legal jump-target mode using pc.
module ext_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc,
    input  logic [2:0]        eop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ext,
    output logic              err,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] head_ext_q, head_ext_d, tail_ext_q, tail_ext_d;
    logic              head_err_q, head_err_d, tail_err_q, tail_err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [15:0]       imm;
    logic [DATA_W-1:0] res_ext;
    logic              res_err;
    logic              acc, cons;

    assign imm = instr[15:0];

`ifdef EXT_JUMP_EN
    logic unused_instr;
    assign unused_instr = ^instr[31:26];
`else
    logic unused_in;
    assign unused_in = ^{pc, instr[31:16]};
`endif

    always_comb begin
        res_ext = '0;
        res_err = 1'b0;
        case (eop)
            3'b000: res_ext = DATA_W'($signed(imm));
            3'b001: res_ext = DATA_W'(imm);
            3'b010: res_ext = DATA_W'($signed({imm, 16'h0000}));
            3'b011: res_ext = DATA_W'($signed({imm, 2'b00}));
`ifdef EXT_JUMP_EN
            3'b101: res_ext = {pc[DATA_W-1:28], instr[25:0], 2'b00};
`endif
            default: begin
                res_ext = '0;
                res_err = 1'b1;
            end
        endcase
    end

    assign acc  = in_valid && in_ready_q;
    assign cons = out_valid_q && out_ready;

    always_comb begin
        state_d    = state_q;
        head_ext_d = head_ext_q;
        head_err_d = head_err_q;
        tail_ext_d = tail_ext_q;
        tail_err_d = tail_err_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            StEmpty: begin
                if (acc) begin
                    head_ext_d = res_ext;
                    head_err_d = res_err;
                    state_d    = StOne;
                end
            end
            StOne: begin
                if (acc && cons) begin
                    head_ext_d = res_ext;
                    head_err_d = res_err;
                end else if (acc) begin
                    tail_ext_d = res_ext;
                    tail_err_d = res_err;
                    state_d    = StTwo;
                end else if (cons) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                // in_ready is low here, so only a consume can happen
                if (cons) begin
                    head_ext_d = tail_ext_q;
                    head_err_d = tail_err_q;
                    state_d    = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (acc && res_err && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
        in_ready_d  = (state_d != StTwo);
        out_valid_d = (state_d != StEmpty);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            head_ext_q  <= '0;
            head_err_q  <= 1'b0;
            tail_ext_q  <= '0;
            tail_err_q  <= 1'b0;
            err_cnt_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_ext_q  <= head_ext_d;
            head_err_q  <= head_err_d;
            tail_ext_q  <= tail_ext_d;
            tail_err_q  <= tail_err_d;
            err_cnt_q   <= err_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign ext       = head_ext_q;
    assign err       = head_err_q;
    assign err_cnt   = err_cnt_q;

endmodule
